// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   Memory-stage controller for a simple pipeline. It selects the next PC,
//   passes the ALU result through, and runs one memory access at a time
//   (load or store) over a req/ack handshake. The pipeline is stalled while
//   an access is being issued or is outstanding. A bounded wait turns a
//   missing acknowledge into a sticky bus error.
//
//   Ports
//     clk, rst_n      clock (rising edge), async active-low reset
//     pc_inc_2        sequential PC
//     pc_branch       branch target
//     PCSrc           branch select
//     aluResult       access address / ALU result
//     writeData       store data
//     memRead         load request
//     memWrite        store request (wins over memRead)
//     pc_out          next PC (combinational)
//     pc_en           PC / pipeline advance enable (combinational, ~stall)
//     stall           pipeline hold (combinational)
//     alu_out         ALU result pass-through (combinational)
//     readData        registered load data
//     mem_req         registered memory request
//     mem_we          registered write strobe
//     mem_addr        registered access address
//     mem_wdata       registered store data
//     mem_ack         memory completion
//     mem_rdata       memory read data, valid with mem_ack
//     bus_err         sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_inc_2,
    input  logic [ADDR_W-1:0] pc_branch,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] aluResult,
    input  logic [DATA_W-1:0] writeData,
    input  logic              memRead,
    input  logic              memWrite,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_en,
    output logic              stall,
    output logic [ADDR_W-1:0] alu_out,
    output logic [DATA_W-1:0] readData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    // Wait counter is wide enough for the largest legal TIMEOUT (255).
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             acc_rd;
    logic             req_c;
    logic             timeout_c;

    // Next-PC select and ALU pass-through.
    assign pc_out  = PCSrc ? pc_branch : pc_inc_2;
    assign alu_out = aluResult;
    assign pc_en   = ~stall;

    assign req_c = memRead | memWrite;

    // The counter holds the number of BUSY cycles already spent without ack,
    // so the TIMEOUT-th ack-less BUSY cycle is the one that gives up. An ack
    // on that same cycle takes priority.
    assign timeout_c = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !mem_ack;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and combinational stall.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_c) begin
                    stall     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack || timeout_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory interface, load data, wait counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            readData  <= '0;
            bus_err   <= 1'b0;
            wait_cnt  <= '0;
            acc_rd    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_c) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memWrite;
                        mem_addr  <= aluResult;
                        mem_wdata <= writeData;
                        // A simultaneous read and write is treated as a write.
                        acc_rd    <= ~memWrite;
                        wait_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (acc_rd) begin
                            readData <= mem_rdata;
                        end
                    end else if (timeout_c) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                        if (acc_rd) begin
                            readData <= '1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//   Self-checking bench for mem_stage_ctrl. Each access is described as a
//   transaction (kind, address, data, ack delay); the expected cycle counts,
//   load data and error flag are derived from that description and compared
//   cycle by cycle against the DUT.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] pc_inc_2;
    logic [ADDR_W-1:0] pc_branch;
    logic              PCSrc;
    logic [ADDR_W-1:0] aluResult;
    logic [DATA_W-1:0] writeData;
    logic              memRead;
    logic              memWrite;
    logic [ADDR_W-1:0] pc_out;
    logic              pc_en;
    logic              stall;
    logic [ADDR_W-1:0] alu_out;
    logic [DATA_W-1:0] readData;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              bus_err;

    int n_vec;
    int n_err;

    // Reference state: last load result and sticky error.
    logic [DATA_W-1:0] m_rd;
    logic              m_err;

    mem_stage_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_inc_2 (pc_inc_2),
        .pc_branch(pc_branch),
        .PCSrc    (PCSrc),
        .aluResult(aluResult),
        .writeData(writeData),
        .memRead  (memRead),
        .memWrite (memWrite),
        .pc_out   (pc_out),
        .pc_en    (pc_en),
        .stall    (stall),
        .alu_out  (alu_out),
        .readData (readData),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc();
        logic [ADDR_W-1:0] exp_pc;
        pc_inc_2  = ADDR_W'($urandom);
        pc_branch = ADDR_W'($urandom);
        PCSrc     = 1'($urandom_range(0, 1));
        exp_pc    = PCSrc ? pc_branch : pc_inc_2;
        #1;
        chk("pc_out", 32'(pc_out), 32'(exp_pc));
        chk("alu_out", 32'(alu_out), 32'(aluResult));
    endtask

    // One access starting in IDLE. ack_dly = n acks on the n-th BUSY cycle;
    // any value outside 1..TIMEOUT means no ack at all.
    task automatic run_access(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                              input int ack_dly);
        bit is_wr;
        bit is_rd;
        bit hit;
        int nbusy;
        is_wr = wr;
        is_rd = rd & ~wr;
        hit   = (ack_dly >= 1) && (ack_dly <= int'(TIMEOUT));
        nbusy = hit ? ack_dly : int'(TIMEOUT);

        memRead   = rd;
        memWrite  = wr;
        aluResult = addr;
        writeData = wdata;
        mem_ack   = 1'b0;
        chk_pc();
        chk("issue_stall", 32'(stall), 32'd1);
        chk("issue_pc_en", 32'(pc_en), 32'd0);
        tick();
        memRead  = 1'b0;
        memWrite = 1'b0;
        aluResult = ADDR_W'($urandom);
        writeData = DATA_W'($urandom);
        for (int b = 1; b <= nbusy; b++) begin
            mem_ack   = hit && (b == ack_dly);
            mem_rdata = mem_ack ? rdata : DATA_W'($urandom);
            #1;
            chk("busy_stall", 32'(stall), 32'd1);
            chk("busy_req", 32'(mem_req), 32'd1);
            chk("busy_we", 32'(mem_we), 32'(is_wr));
            chk("busy_addr", 32'(mem_addr), 32'(addr));
            chk("busy_wdata", 32'(mem_wdata), 32'(wdata));
            chk("busy_rdata", 32'(readData), 32'(m_rd));
            chk("busy_err", 32'(bus_err), 32'(m_err));
            tick();
        end
        if (is_rd) m_rd = hit ? rdata : '1;
        if (!hit) m_err = 1'b1;

        // DONE: request inputs and a stray ack must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = DATA_W'($urandom);
        memRead   = 1'($urandom_range(0, 1));
        memWrite  = 1'($urandom_range(0, 1));
        #1;
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_pc_en", 32'(pc_en), 32'd1);
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_rdata", 32'(readData), 32'(m_rd));
        chk("done_err", 32'(bus_err), 32'(m_err));
        tick();
        chk("idle_req", 32'(mem_req), 32'd0);
        chk("idle_rdata", 32'(readData), 32'(m_rd));
        memRead  = 1'b0;
        memWrite = 1'b0;
        mem_ack  = 1'b0;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_pc_en", 32'(pc_en), 32'd1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_rd      = '0;
        m_err     = 1'b0;
        rst_n     = 1'b0;
        pc_inc_2  = '0;
        pc_branch = '0;
        PCSrc     = 1'b0;
        aluResult = '0;
        writeData = '0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(readData), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        #12;
        rst_n = 1'b1;
        tick();

        // Directed PC mux values.
        PCSrc = 1'b1; pc_branch = 16'h0100; pc_inc_2 = 16'h0022;
        #1;
        chk("pc_branch", 32'(pc_out), 32'h0100);
        PCSrc = 1'b0;
        #1;
        chk("pc_seq", 32'(pc_out), 32'h0022);
        chk("pc_en_idle", 32'(pc_en), 32'd1);

        // Single-cycle-ack load, delayed store, timeout, then a good load.
        run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1);
        run_access(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h5555, 4);
        run_access(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h7777, 0);
        chk("timeout_rdata", 32'(readData), 32'hFFFF);
        run_access(1'b1, 1'b0, 16'h0044, 16'h0000, 16'hCAFE, 2);
        chk("err_sticky", 32'(bus_err), 32'd1);
        // Ack arriving on the timeout cycle wins.
        run_access(1'b1, 1'b0, 16'h0300, 16'h0000, 16'hA5A5, int'(TIMEOUT));
        // Back-to-back loads.
        run_access(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h1111, 1);
        run_access(1'b1, 1'b0, 16'h0052, 16'h0000, 16'h2222, 1);

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            run_access(op != 1, op != 0, ADDR_W'($urandom), DATA_W'($urandom),
                       DATA_W'($urandom), int'($urandom_range(1, TIMEOUT + 3)));
        end

        // Read/write conflict, then reset in the middle of BUSY.
        memRead   = 1'b1;
        memWrite  = 1'b1;
        aluResult = 16'h0080;
        writeData = 16'h4321;
        tick();
        memRead  = 1'b0;
        memWrite = 1'b0;
        #1;
        chk("conflict_we", 32'(mem_we), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_rdata", 32'(readData), 32'd0);
        chk("abort_err", 32'(bus_err), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        m_rd  = '0;
        m_err = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_stall", 32'(stall), 32'd0);
        run_access(1'b1, 1'b0, 16'h0060, 16'h0000, 16'h0F0F, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
